// File: rtl/drive_mixer_if.sv
// drive_mixer_if: RC sample input, enable, and motor drive outputs of drive_mixer.
interface drive_mixer_if #(
    parameter int unsigned PULSE_W = 17,
    parameter int unsigned OUT_W   = 12
);
    logic               in_valid;
    logic [PULSE_W-1:0] rc1;
    logic [PULSE_W-1:0] rc2;
    logic               enable;
    logic [OUT_W-1:0]   motor1;
    logic [OUT_W-1:0]   motor2;
    logic               out_valid;
    logic               failsafe;

    modport master (
        output in_valid, rc1, rc2, enable,
        input  motor1, motor2, out_valid, failsafe
    );

    modport slave (
        input  in_valid, rc1, rc2, enable,
        output motor1, motor2, out_valid, failsafe
    );
endinterface

// File: rtl/drive_mixer.sv
// drive_mixer: RC throttle/steering pulse pair -> two sign-magnitude motor drives.
// Pipeline: pulse conversion -> mix targets (with watchdog failsafe) -> output registers.
// Define DRIVE_MIXER_SLEW_EN to rate-limit the outputs toward their targets.
module drive_mixer #(
    parameter int unsigned PULSE_W   = 17,
    parameter int unsigned MIX_W     = 10,
    parameter int unsigned OUT_W     = 12,
    parameter int          CENTER    = 1500,
    parameter int          DEADBAND  = 10,
    parameter int          MIN_LEN   = 990,
    parameter int          MAX_LEN   = 2011,
    parameter int unsigned TIMEOUT   = 1000000,
    parameter int          SLEW_STEP = 16,
    parameter int          RAMP_DIV  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    drive_mixer_if.slave bus
);
    localparam int          LIM    = (1 << (MIX_W - 1)) - 1;
    localparam int unsigned MAG_W  = MIX_W - 1;
    localparam int unsigned BODY_W = OUT_W - 1;
    localparam int unsigned SH     = OUT_W - MIX_W;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);
`ifdef DRIVE_MIXER_SLEW_EN
    localparam bit          RAMP_ON = 1'b1;
`else
    localparam bit          RAMP_ON = 1'b0;
`endif
    // Without ramping, a full-range step every cycle makes the outputs load targets directly.
    localparam int          STEP   = RAMP_ON ? SLEW_STEP : 2 * LIM;
    localparam int          DIV    = RAMP_ON ? RAMP_DIV : 1;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

    function automatic int sat(input int x);
        if (x > LIM)       return LIM;
        else if (x < -LIM) return -LIM;
        else               return x;
    endfunction

    function automatic logic signed [MIX_W-1:0] convert(input logic [PULSE_W-1:0] p);
        int pi;
        int d;
        int v;
        pi = int'(p);
        d  = pi - CENTER;
        if (pi < MIN_LEN)                          v = -LIM;
        else if (pi > MAX_LEN)                     v = LIM;
        else if (d > -DEADBAND && d < DEADBAND)    v = 0;
        else                                       v = sat(d);
        return MIX_W'(v);
    endfunction

    function automatic void mix(input int x1, input int x2, output int o1, output int o2);
        int a;
        int s;
        a = sat(x1 + x2);
        s = sat(x1 - x2);
        if (x2 < 0) begin
            if (x1 < 0)       begin o1 = s; o2 = x1; end
            else if (x1 == 0) begin o1 = a; o2 = s;  end
            else              begin o1 = a; o2 = x1; end
        end else if (x1 == 0) begin
            o1 = x2; o2 = s;
        end else begin
            o1 = x1; o2 = (x1 < 0) ? a : s;
        end
    endfunction

    function automatic logic signed [MIX_W-1:0] step_to(input logic signed [MIX_W-1:0] cur,
                                                         input logic signed [MIX_W-1:0] tgt);
        int d;
        int r;
        d = int'(tgt) - int'(cur);
        if (d > STEP)       r = int'(cur) + STEP;
        else if (d < -STEP) r = int'(cur) - STEP;
        else                r = int'(tgt);
        return MIX_W'(r);
    endfunction

    function automatic logic [OUT_W-1:0] encode(input logic signed [MIX_W-1:0] m);
        logic [MAG_W-1:0]  mag;
        logic [BODY_W-1:0] body;
        mag  = m[MIX_W-1] ? MAG_W'(-m) : m[MAG_W-1:0];
        body = BODY_W'(mag) << SH;
        for (int unsigned i = 0; i < SH; i++) body[i] = mag[0];
        return {m[MIX_W-1], body};
    endfunction

    logic                    s1_valid;
    logic signed [MIX_W-1:0] c1, c2;
    logic signed [MIX_W-1:0] t1, t2;
    logic signed [MIX_W-1:0] cur1, cur2;
    logic signed [MIX_W-1:0] cur1_nx, cur2_nx;
    logic [WD_W-1:0]         wd;
    logic                    fs;
    logic [DIV_W-1:0]        div, div_nx;
    logic [OUT_W-1:0]        m1, m2, m1_nx, m2_nx;
    logic                    ov;
    logic                    expire_c;
    logic                    tick_c;
    int                      mt1, mt2;

    // A sample arriving on the expiry cycle takes priority over the watchdog.
    assign expire_c = (wd == '0) && !bus.in_valid;
    assign tick_c   = (div == DIV_W'(DIV - 1));

    // Stage 1: convert pulse lengths to signed channel values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            c1       <= '0;
            c2       <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                c1 <= convert(bus.rc1);
                c2 <= convert(bus.rc2);
            end
        end
    end

    // Mixing rules applied to the stage-1 channel values.
    always_comb begin
        mt1 = 0;
        mt2 = 0;
        mix(int'(c1), int'(c2), mt1, mt2);
    end

    // Stage 2: load targets from a fresh sample, or zero them on watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= '0;
            t2 <= '0;
            fs <= 1'b0;
        end else if (s1_valid) begin
            t1 <= MIX_W'(mt1);
            t2 <= MIX_W'(mt2);
            fs <= 1'b0;
        end else if (expire_c) begin
            t1 <= '0;
            t2 <= '0;
            fs <= 1'b1;
        end
    end

    // Sample watchdog: reload on each sample, count down to zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             wd <= WD_W'(TIMEOUT);
        else if (bus.in_valid)  wd <= WD_W'(TIMEOUT);
        else if (wd != '0)      wd <= wd - 1'b1;
    end

    // Next slew state and encoded outputs; enable low zeroes everything at once.
    always_comb begin
        cur1_nx = cur1;
        cur2_nx = cur2;
        div_nx  = div + 1'b1;
        if (!bus.enable) begin
            cur1_nx = '0;
            cur2_nx = '0;
            div_nx  = '0;
        end else if (tick_c) begin
            cur1_nx = step_to(cur1, t1);
            cur2_nx = step_to(cur2, t2);
            div_nx  = '0;
        end
        m1_nx = encode(cur1_nx);
        m2_nx = encode(cur2_nx);
    end

    // Output registers; out_valid marks cycles where either drive value changed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur1 <= '0;
            cur2 <= '0;
            div  <= '0;
            m1   <= '0;
            m2   <= '0;
            ov   <= 1'b0;
        end else begin
            cur1 <= cur1_nx;
            cur2 <= cur2_nx;
            div  <= div_nx;
            m1   <= m1_nx;
            m2   <= m2_nx;
            ov   <= (m1_nx != m1) || (m2_nx != m2);
        end
    end

    assign bus.motor1    = m1;
    assign bus.motor2    = m2;
    assign bus.out_valid = ov;
    assign bus.failsafe  = fs;
endmodule

// File: tb/tb_drive_mixer.sv
// tb_drive_mixer: directed and randomized checks of drive_mixer against a behavioural model.
// The ramp checks are selected when DRIVE_MIXER_SLEW_EN is defined.
module tb_drive_mixer;
    localparam int unsigned PULSE_W   = 17;
    localparam int unsigned MIX_W     = 10;
    localparam int unsigned OUT_W     = 12;
    localparam int          TIMEOUT_T = 1000;
    localparam int          LIM       = 511;
    localparam int          SH        = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   cmp_on = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    drive_mixer_if #(.PULSE_W(PULSE_W), .OUT_W(OUT_W)) bus ();

    drive_mixer #(
        .PULSE_W(PULSE_W), .MIX_W(MIX_W), .OUT_W(OUT_W),
        .CENTER(1500), .DEADBAND(10), .MIN_LEN(990), .MAX_LEN(2011),
        .TIMEOUT(TIMEOUT_T), .SLEW_STEP(16), .RAMP_DIV(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("%0t FAIL %s got=%0h want=%0h", $time, name, act, exp);
        end
    endtask

    // Behavioural reference: pulse -> channel value.
    function automatic int m_conv(input int p);
        int d;
        if (p < 990) return -LIM;
        if (p > 2011) return LIM;
        d = p - 1500;
        if (d < 10 && d > -10) return 0;
        if (d > LIM) return LIM;
        if (d < -LIM) return -LIM;
        return d;
    endfunction

    function automatic int m_clip(input int x);
        return (x > LIM) ? LIM : ((x < -LIM) ? -LIM : x);
    endfunction

    function automatic void m_targets(input int c1, input int c2, output int o1, output int o2);
        int a;
        int s;
        a = m_clip(c1 + c2);
        s = m_clip(c1 - c2);
        if (c2 < 0 && c1 < 0)       begin o1 = s;  o2 = c1; end
        else if (c2 < 0 && c1 == 0) begin o1 = a;  o2 = s;  end
        else if (c2 < 0)            begin o1 = a;  o2 = c1; end
        else if (c1 == 0)           begin o1 = c2; o2 = s;  end
        else                        begin o1 = c1; o2 = (c1 < 0) ? a : s; end
    endfunction

    // Sign-magnitude with the magnitude scaled by 2^SH and low bits copying its LSB.
    function automatic int m_enc(input int m);
        int mag;
        int v;
        mag = (m < 0) ? -m : m;
        v = mag * (1 << SH) + ((mag % 2 == 1) ? (1 << SH) - 1 : 0);
        if (m < 0) v += (1 << (OUT_W - 1));
        return v;
    endfunction

    // Model state, indexed by clock edge count since reset.
    int edge_n, last_iv, pr1, pr2, mt1, mt2, me1, me2, mov, mfs;
    bit pend;

    always @(posedge clk or negedge rst_n) begin
        int n1;
        int n2;
        if (!rst_n) begin
            edge_n = 0; last_iv = 0; pend = 0; pr1 = 0; pr2 = 0;
            mt1 = 0; mt2 = 0; me1 = 0; me2 = 0; mov = 0; mfs = 0;
        end else begin
            edge_n++;
            n1  = bus.enable ? m_enc(mt1) : 0;
            n2  = bus.enable ? m_enc(mt2) : 0;
            mov = (n1 != me1 || n2 != me2) ? 1 : 0;
            me1 = n1;
            me2 = n2;
            if (pend) begin
                m_targets(m_conv(pr1), m_conv(pr2), mt1, mt2);
                mfs = 0;
            end else if (!bus.in_valid && (edge_n - last_iv) > TIMEOUT_T) begin
                mt1 = 0; mt2 = 0; mfs = 1;
            end
            pend = bus.in_valid;
            if (bus.in_valid) begin
                pr1 = int'(bus.rc1);
                pr2 = int'(bus.rc2);
                last_iv = edge_n;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
`ifndef DRIVE_MIXER_SLEW_EN
            check("cyc_motor1", int'(bus.motor1), me1);
            check("cyc_motor2", int'(bus.motor2), me2);
            check("cyc_out_valid", int'(bus.out_valid), mov);
`endif
            check("cyc_failsafe", int'(bus.failsafe), mfs);
        end
    end

    task automatic sample(input int r1, input int r2);
        bus.rc1 = PULSE_W'(r1);
        bus.rc2 = PULSE_W'(r2);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic int pick_pulse();
        int edges[10] = '{989, 990, 2011, 2012, 1490, 1491, 1509, 1510, 1500, 3000};
        if ($urandom % 3 == 0) return edges[$urandom % 10];
        return int'($urandom_range(900, 2100));
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.rc1 = PULSE_W'(1500);
        bus.rc2 = PULSE_W'(1500);
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_motor1", int'(bus.motor1), 0);
        check("rst_motor2", int'(bus.motor2), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_failsafe", int'(bus.failsafe), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cmp_on = 1'b1;
        @(negedge clk);

`ifndef DRIVE_MIXER_SLEW_EN
        sample(1700, 1500);
        @(negedge clk);
        check("lat_early_ov", int'(bus.out_valid), 0);
        @(negedge clk);
        check("lat_ov", int'(bus.out_valid), 1);
        check("fwd_motor1", int'(bus.motor1), 'h320);
        check("fwd_motor2", int'(bus.motor2), 'h320);

        sample(1700, 1300);
        repeat (2) @(negedge clk);
        check("turn_motor1", int'(bus.motor1), 'h000);
        check("turn_motor2", int'(bus.motor2), 'h320);

        sample(2100, 2100);
        repeat (2) @(negedge clk);
        check("max_motor1", int'(bus.motor1), 'h7FF);
        check("max_motor2", int'(bus.motor2), 'h000);

        sample(1505, 1495);
        repeat (2) @(negedge clk);
        check("dead_motor1", int'(bus.motor1), 0);
        check("dead_motor2", int'(bus.motor2), 0);

        sample(1700, 1500);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        check("en_off_motor1", int'(bus.motor1), 0);
        check("en_off_ov", int'(bus.out_valid), 1);
        bus.enable = 1'b1;
        @(negedge clk);
        check("en_on_motor1", int'(bus.motor1), 'h320);

        repeat (1005) @(negedge clk);
        check("wd_failsafe", int'(bus.failsafe), 1);
        check("wd_motor1", int'(bus.motor1), 0);
        sample(1700, 1500);
        @(negedge clk);
        check("wd_clear", int'(bus.failsafe), 0);
        @(negedge clk);
        check("wd_resume", int'(bus.motor1), 'h320);

        // Sample lands exactly on the expiry edge: no failsafe.
        repeat (1000) @(negedge clk);
        sample(1600, 1500);
        repeat (3) @(negedge clk);
        check("wd_coincide", int'(bus.failsafe), 0);

        // Reset with a sample in flight.
        sample(1900, 1500);
        @(posedge clk); #1 rst_n = 1'b0;
        #1 check("rst_mid_motor1", int'(bus.motor1), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_rel_motor1", int'(bus.motor1), 0);
        check("rst_rel_ov", int'(bus.out_valid), 0);
`else
        begin
            int k;
            int v;
            k = 0;
            sample(1700, 1500);
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (bus.out_valid) begin
                    k++;
                    v = (k * 16 < 200) ? k * 16 : 200;
                    check("ramp_step", int'(bus.motor1), m_enc(v));
                end
            end
            check("ramp_pulses", k, 13);
            check("ramp_final1", int'(bus.motor1), 'h320);
            check("ramp_final2", int'(bus.motor2), 'h320);

            sample(1500, 1500);
            repeat (60) @(negedge clk);
            sample(1900, 1500);
            repeat (10) @(negedge clk);
            bus.enable = 1'b0;
            @(negedge clk);
            check("en_drop_motor1", int'(bus.motor1), 0);
            check("en_drop_motor2", int'(bus.motor2), 0);
            bus.enable = 1'b1;
            repeat (10) @(negedge clk);
            @(posedge clk); #1 rst_n = 1'b0;
            #1 check("rst_ramp_motor1", int'(bus.motor1), 0);
            check("rst_ramp_motor2", int'(bus.motor2), 0);
            @(posedge clk); #1 rst_n = 1'b1;
            k = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (bus.out_valid) k++;
            end
            check("rst_ramp_quiet", k, 0);
        end
`endif

        // Dense random samples with occasional enable drops.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid = ($urandom % 3 == 0);
            bus.rc1 = PULSE_W'(pick_pulse());
            bus.rc2 = PULSE_W'(pick_pulse());
            bus.enable = ($urandom % 16 != 0);
            @(negedge clk);
        end
        // Sparse samples so the watchdog expires and recovers.
        bus.enable = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            bus.in_valid = ($urandom % 700 == 0);
            bus.rc1 = PULSE_W'(pick_pulse());
            bus.rc2 = PULSE_W'(pick_pulse());
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/drive_mixer.md
DRIVE_MIXER -- requirements
Module: drive_mixer

Interface
REQ-001 Parameter PULSE_W, default 17: width of RC pulse-length inputs, in microseconds.
REQ-002 Parameter MIX_W, default 10: two's-complement width of internal channel and mix values.
REQ-003 Parameter OUT_W, default 12: width of each sign-magnitude motor output; OUT_W >= MIX_W.
REQ-004 Parameters CENTER 1500, DEADBAND 10, MIN_LEN 990, MAX_LEN 2011: pulse conversion limits, in microseconds.
REQ-005 Parameter TIMEOUT, default 1000000: clk cycles without a sample before failsafe.
REQ-006 Parameters SLEW_STEP 16 and RAMP_DIV 4: slew increment, and clk cycles per slew tick.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  one-cycle strobe; rc1/rc2 hold a new sample.
REQ-010 rc1  in  PULSE_W  throttle pulse length; rc2  in  PULSE_W  steering pulse length.
REQ-011 enable  in  1  level; low forces both motors to zero.
REQ-012 motor1, motor2  out  OUT_W  sign-magnitude drive; MSB is sign.
REQ-013 out_valid  out  1  one-cycle strobe whenever motor1/motor2 change.
REQ-014 failsafe  out  1  level; high while the sample watchdog has expired.

Function
REQ-015 Stage 1, registered on in_valid: convert each pulse p to a signed MIX_W value c as follows.
- p < MIN_LEN gives -LIM; p > MAX_LEN gives +LIM, where LIM = 2^(MIX_W-1)-1.
- |p-CENTER| < DEADBAND gives 0.
- Otherwise c = p-CENTER, clamped to +/-LIM.
REQ-016 Stage 2, registered one cycle after stage 1: compute targets t1/t2 with a = sat(c1+c2) and s = sat(c1-c2), saturating to +/-LIM.
- c2<0 and c1<0: t1=s, t2=c1.
- c2<0 and c1=0: t1=a, t2=s.
- c2<0 and c1>0: t1=a, t2=c1.
- c2>=0 and c1=0: t1=c2, t2=s.
- c2>=0 and c1!=0: t1=c1, t2=(c1<0 ? a : s).
REQ-017 The pipeline accepts in_valid every cycle; stage-2 targets are available two cycles after in_valid.
REQ-018 Output encoding for motor value m:
- sign bit = m<0.
- magnitude = |m| (MIX_W-1 bits), left-shifted by OUT_W-MIX_W.
- vacated low bits are filled with copies of bit 0 of |m|.
REQ-019 Watchdog: a counter reloads on every in_valid and counts down otherwise.
- At zero, failsafe asserts and both targets are forced to 0.
- failsafe clears on the cycle the next sample's stage-2 targets load.
REQ-020 If in_valid coincides with watchdog expiry, in_valid wins: the counter reloads and failsafe stays unchanged.
REQ-021 When enable is low, the output registers and slew state become 0 on the next cycle, bypassing the slew limiter; targets are still computed.
REQ-022 Motor outputs update and out_valid pulses only when an output register value actually changes.

Reset
REQ-023 When rst_n is low, all of the following clear asynchronously:
- motor1, motor2 = 0; out_valid = 0; failsafe = 0.
- pipeline registers = 0.
- slew divider = 0; watchdog = TIMEOUT.
REQ-024 Reset mid-ramp or mid-pipeline discards all in-flight data; no out_valid fires on rst_n release.

Configuration
REQ-025 Macro DRIVE_MIXER_SLEW_EN, when defined: the output registers move toward their targets.
- Each move happens once per RAMP_DIV cycles, by at most SLEW_STEP, and never overshoots.
- Both channels step independently.
REQ-026 Macro DRIVE_MIXER_SLEW_EN, when undefined: the output registers load the targets directly, three cycles after in_valid (one cycle after stage 2); SLEW_STEP and RAMP_DIV are unused.

Verification (defaults; slew undefined unless stated)
REQ-027 rc1=1700, rc2=1500, enable=1 -> motor1 = motor2 = 12'h320, with out_valid three cycles after in_valid.
REQ-028 rc1=1700, rc2=1300 -> motor1 = 12'h000, motor2 = 12'h320.
REQ-029 Pulse boundaries:
- rc1=2100, rc2=2100 -> motor1 = 12'h7FF, motor2 = 12'h000.
- rc1=1505, rc2=1495 -> both outputs 0.
REQ-030 Watchdog: one sample of 1700/1500, then no in_valid for 1000 cycles -> failsafe=1 and outputs 0; the next sample clears failsafe.
REQ-031 With DRIVE_MIXER_SLEW_EN: target 200 from 0 -> magnitude steps 16,32,...,192,200 every 4 cycles, 13 out_valid pulses in total.
REQ-032 rst_n asserted mid-ramp, or enable dropped mid-ramp -> outputs reach 0 immediately; no overshoot after release.
